// File: rtl/a2d_pkg.sv
// a2d_pkg: constants and types shared by the load-cell A2D interface.
//   LFT_CH/RGHT_CH/STEER_CH/BATT_CH : A2D channel numbers for each reading
//   a2d_state_t                     : round-robin sequencer states
//   spi_state_t                     : SPI master states
//   rr_chan()                       : round-robin index to A2D channel
package a2d_pkg;

  localparam logic [2:0] LFT_CH   = 3'd0;
  localparam logic [2:0] RGHT_CH  = 3'd4;
  localparam logic [2:0] STEER_CH = 3'd5;
  localparam logic [2:0] BATT_CH  = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    GAP  = 2'd2,
    READ = 2'd3
  } a2d_state_t;

  typedef enum logic [1:0] {
    SPI_IDLE  = 2'd0,
    SPI_FRONT = 2'd1,
    SPI_XFER  = 2'd2
  } spi_state_t;

  function automatic logic [2:0] rr_chan(input logic [1:0] idx);
    logic [2:0] ch;
    case (idx)
      2'd0:    ch = LFT_CH;
      2'd1:    ch = RGHT_CH;
      2'd2:    ch = STEER_CH;
      default: ch = BATT_CH;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/spi_mnrch.sv
// spi_mnrch: 16-bit SPI master, mode 3 (SCLK idles high, MOSI changes on
// SCLK fall, MISO sampled on SCLK rise), MSB first.
//   clk, rst         : system clock, synchronous active-high reset
//   wrt, wt_data     : start a transaction with this transmit word (ignored while busy)
//   done             : one-cycle pulse; SS_n rises on the edge that ends it
//   rd_data          : word shifted in from MISO
//   SS_n, SCLK, MOSI : SPI outputs; MISO : SPI input
module spi_mnrch
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] wt_data,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam int HALF = SCLK_DIV / 2;
  localparam int HW   = (HALF > 2) ? $clog2(HALF) : 1;
  localparam logic [HW-1:0] HALF_LD = HW'(HALF - 1);
  // 32 SCLK edges plus the trailing half period before SS_n rises
  localparam logic [5:0] EDGES_LD = 6'd33;

  spi_state_t     state_q, state_d;
  logic [HW-1:0]  half_q, half_d;
  logic [5:0]     edg_q, edg_d;
  logic [15:0]    tx_q, tx_d;
  logic [15:0]    rx_q, rx_d;
  logic           ss_n_q, ss_n_d;
  logic           sclk_q, sclk_d;
  logic           tick;

  assign tick    = (half_q == '0);
  assign rd_data = rx_q;
  assign SS_n    = ss_n_q;
  assign SCLK    = sclk_q;
  assign MOSI    = tx_q[15];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SPI_IDLE;
      half_q  <= '0;
      edg_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      ss_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      edg_q   <= edg_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      ss_n_q  <= ss_n_d;
      sclk_q  <= sclk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    edg_d   = edg_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    ss_n_d  = ss_n_q;
    sclk_d  = sclk_q;
    done    = 1'b0;
    case (state_q)
      SPI_IDLE: begin
        if (wrt) begin
          tx_d    = wt_data;
          state_d = SPI_FRONT;
        end
      end
      SPI_FRONT: begin
        ss_n_d  = 1'b0;
        half_d  = HALF_LD;
        edg_d   = EDGES_LD;
        state_d = SPI_XFER;
      end
      SPI_XFER: begin
        if (!tick) begin
          half_d = half_q - 1'b1;
        end else begin
          half_d = HALF_LD;
          if (edg_q == 6'd1) begin
            done    = 1'b1;
            ss_n_d  = 1'b1;
            sclk_d  = 1'b1;
            state_d = SPI_IDLE;
          end else begin
            edg_d = edg_q - 1'b1;
            if (edg_q[0]) begin
              // falling edge; MSB is already on MOSI before the first fall
              sclk_d = 1'b0;
              if (edg_q != EDGES_LD) tx_d = {tx_q[14:0], 1'b0};
            end else begin
              sclk_d = 1'b1;
              rx_d   = {rx_q[14:0], MISO};
            end
          end
        end
      end
      default: state_d = SPI_IDLE;
    endcase
  end

endmodule

// File: rtl/load_cell_a2d_intf.sv
// load_cell_a2d_intf: round-robin sequencer that converts left load cell,
// right load cell, steering pot and battery through an external 8-channel
// 12-bit SPI A2D, one reading per nxt request.
//   clk, rst                      : system clock, synchronous active-high reset
//   nxt                           : start the next conversion (honoured only when idle)
//   lft_ld, rght_ld, steer_pot, batt : latest 12-bit readings
//   SS_n, SCLK, MOSI, MISO        : SPI link to the A2D
//
// state | meaning
// IDLE  | waiting for nxt
// CMD   | transaction 1: sending channel command
// GAP   | one clock with SS_n high between the two transactions
// READ  | transaction 2: reading back the conversion result
module load_cell_a2d_intf
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  a2d_state_t  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [11:0] lft_q, lft_d;
  logic [11:0] rght_q, rght_d;
  logic [11:0] steer_q, steer_d;
  logic [11:0] batt_q, batt_d;
  logic        wrt;
  logic [15:0] wt_data;
  logic        spi_done;
  logic [15:0] rd_data;

  spi_mnrch #(
    .SCLK_DIV (SCLK_DIV)
  ) u_spi (
    .clk     (clk),
    .rst     (rst),
    .wrt     (wrt),
    .wt_data (wt_data),
    .done    (spi_done),
    .rd_data (rd_data),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  assign lft_ld    = lft_q;
  assign rght_ld   = rght_q;
  assign steer_pot = steer_q;
  assign batt      = batt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      lft_q   <= 12'h000;
      rght_q  <= 12'h000;
      steer_q <= 12'h000;
      batt_q  <= 12'h000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lft_q   <= lft_d;
      rght_q  <= rght_d;
      steer_q <= steer_d;
      batt_q  <= batt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lft_d   = lft_q;
    rght_d  = rght_q;
    steer_d = steer_q;
    batt_d  = batt_q;
    wrt     = 1'b0;
    wt_data = 16'h0000;
    case (state_q)
      IDLE: begin
        if (nxt) begin
          wrt     = 1'b1;
          wt_data = {2'b00, rr_chan(idx_q), 11'h000};
          state_d = CMD;
        end
      end
      CMD: begin
        if (spi_done) state_d = GAP;
      end
      GAP: begin
        // the SPI master is idle again here, so this start is accepted
        wrt     = 1'b1;
        wt_data = 16'h0000;
        state_d = READ;
      end
      READ: begin
        if (spi_done) begin
          case (idx_q)
            2'd0:    lft_d   = rd_data[11:0];
            2'd1:    rght_d  = rd_data[11:0];
            2'd2:    steer_d = rd_data[11:0];
            default: batt_d  = rd_data[11:0];
          endcase
          idx_d   = idx_q + 2'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_cell_a2d_intf.sv
module tb_load_cell_a2d_intf;

  localparam int DIV   = 4;
  localparam int T_SPI = 16*DIV + DIV/2 + 1;
  localparam int LAT   = 2*T_SPI + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        nxt = 1'b0;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic        SS_n, SCLK, MOSI, MISO;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_cell_a2d_intf #(.SCLK_DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .nxt       (nxt),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .steer_pot (steer_pot),
    .batt      (batt),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  // A2D slave: a command frame selects the channel, the next frame returns it
  logic [11:0] a2d_val [8];
  int          bit_idx   = 16;
  logic [15:0] cap       = '0;
  logic [15:0] resp      = '0;
  logic        ss_prev   = 1'b1;
  logic        sclk_prev = 1'b1;
  logic [2:0]  last_ch   = 3'd0;
  int          cyc       = 0;
  int          last_rise = 0;
  int          sclk_bad  = 0;
  int          frames    = 0;
  logic [15:0] frame_data [$];
  int          frame_len  [$];

  assign MISO = (bit_idx < 16) ? resp[4'(15 - bit_idx)] : 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (ss_prev && !SS_n) begin
      bit_idx = 0;
      cap     = '0;
      resp    = {4'h0, a2d_val[last_ch]};
    end
    if (!SS_n && !sclk_prev && SCLK) begin
      if (bit_idx > 0 && (cyc - last_rise) != DIV) sclk_bad = sclk_bad + 1;
      last_rise = cyc;
      cap       = {cap[14:0], MOSI};
      bit_idx   = bit_idx + 1;
    end
    if (!ss_prev && SS_n) begin
      frame_data.push_back(cap);
      frame_len.push_back(bit_idx);
      last_ch = cap[13:11];
      frames  = frames + 1;
      bit_idx = 16;
    end
    ss_prev   = SS_n;
    sclk_prev = SCLK;
  end

  // reference: round-robin slot -> channel, expected reading per slot
  int          chan_map [4] = '{0, 4, 5, 6};
  logic [11:0] exp_out  [4];
  int          rr;

  function automatic logic [11:0] out_of(input int i);
    case (i)
      0:       return lft_ld;
      1:       return rght_ld;
      2:       return steer_pot;
      default: return batt;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_lft"},   {20'h0, lft_ld},    {20'h0, exp_out[0]});
    chk({tag, "_rght"},  {20'h0, rght_ld},   {20'h0, exp_out[1]});
    chk({tag, "_steer"}, {20'h0, steer_pot}, {20'h0, exp_out[2]});
    chk({tag, "_batt"},  {20'h0, batt},      {20'h0, exp_out[3]});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) exp_out[i] = 12'h000;
    rr = 0;
  endtask

  task automatic do_conv(input string tag, input logic [11:0] v, input bit hold);
    int ch, f0, c;
    bit seen;
    ch = chan_map[rr];
    if (v == exp_out[rr]) v = v ^ 12'h001;
    a2d_val[ch] = v;
    f0 = frames;
    chk({tag, "_idle_ss"},   {31'h0, SS_n}, 32'd1);
    chk({tag, "_idle_sclk"}, {31'h0, SCLK}, 32'd1);
    nxt = 1'b1;
    @(posedge clk); #1;
    if (!hold) nxt = 1'b0;
    c = 0;
    seen = 1'b0;
    while (!seen && c < LAT + 40) begin
      @(posedge clk); #1;
      c++;
      if (out_of(rr) !== exp_out[rr]) seen = 1'b1;
    end
    nxt = 1'b0;
    chk({tag, "_latency"}, seen ? c : -1, LAT);
    exp_out[rr] = v;
    rr = (rr + 1) % 4;
    chk_outputs(tag);
    repeat (10) @(posedge clk);
    #1;
    chk({tag, "_frames"}, frames - f0, 2);
    if (frames - f0 >= 2) begin
      chk({tag, "_cmd"},  {16'h0, frame_data[$-1]}, {16'h0, 2'b00, 3'(ch), 11'h000});
      chk({tag, "_rdw"},  {16'h0, frame_data[$]}, 32'h0);
      chk({tag, "_len1"}, frame_len[$-1], 16);
      chk({tag, "_len2"}, frame_len[$], 16);
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    chk({tag, "_ss"},   {31'h0, SS_n}, 32'd1);
    chk({tag, "_sclk"}, {31'h0, SCLK}, 32'd1);
    chk_outputs(tag);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, c, lows;
    bit found;
    for (int i = 0; i < 8; i++) a2d_val[i] = 12'(i * 16 + 3);
    model_reset();

    do_reset("reset");

    // single conversion of the left load cell
    do_conv("single_ch0", 12'hA5C, 1'b0);

    // full round robin from reset
    do_reset("reset2");
    do_conv("rr_ch0", 12'd7,   1'b0);
    do_conv("rr_ch4", 12'd407, 1'b0);
    do_conv("rr_ch5", 12'd507, 1'b0);
    do_conv("rr_ch6", 12'd607, 1'b0);

    // wrap back to channel 0
    do_conv("wrap_ch0", 12'd1234, 1'b0);

    // random readings, some with nxt held high throughout
    for (int k = 0; k < 5; k++)
      do_conv("rand", 12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));

    // nxt asserted every clock during a conversion
    do_conv("nxt_hold", 12'($urandom_range(0, 4095)), 1'b1);

    // reset at bit 8 of the read transaction
    a2d_val[chan_map[rr]] = 12'($urandom_range(1, 4095));
    f0 = frames;
    nxt = 1'b1;
    @(posedge clk); #1;
    nxt = 1'b0;
    found = 1'b0;
    c = 0;
    while (!found && c < 3 * LAT) begin
      @(posedge clk); #1;
      c++;
      if (frames == f0 + 1 && !SS_n && bit_idx == 8) found = 1'b1;
    end
    chk("abort_reach_bit8", {31'h0, found}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("abort_ss",   {31'h0, SS_n}, 32'd1);
    chk("abort_sclk", {31'h0, SCLK}, 32'd1);
    chk_outputs("abort");
    repeat (5) @(posedge clk);
    #1;
    do_conv("after_abort", 12'($urandom_range(0, 4095)), 1'b0);

    // reset and nxt together: nothing starts
    rst = 1'b1;
    nxt = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    nxt = 1'b0;
    model_reset();
    f0 = frames;
    lows = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (!SS_n) lows++;
    end
    chk("rst_nxt_ss_low", lows, 0);
    chk("rst_nxt_frames", frames - f0, 0);
    chk_outputs("rst_nxt");

    chk("sclk_period", sclk_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
